pending_priority_encoder: RTL

- Multi-hot-to-binary encoder: the encode direction of the team's one-hot decoders.
- Captures request bits on `req_in[N-1:0]` into a sticky pending vector.
- Emits one binary index per accepted transfer on a valid/ready output stage, serving requests in fixed priority order.
- Sits between event/interrupt-style request lines and a consumer that handles one index at a time (e.g. a decoder-driven select path).

---
 rtl/pending_priority_encoder_pkg.sv | 33 +++
 rtl/pending_priority_encoder_prio_pick.sv | 36 +++
 rtl/pending_priority_encoder.sv | 90 +++++++++
 3 files changed

// File: rtl/pending_priority_encoder_pkg.sv
// Shared helpers for the pending priority encoder: default width and the
// one-hot / priority-pick functions used by the encoder and its picker.
package pend_enc_pkg;

  localparam int unsigned DEFAULT_N = 8;
  // Widest request vector the helper functions handle.
  localparam int unsigned MAX_N     = 64;

  // One-hot vector with only bit idx set.
  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
    onehot = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (i == idx) onehot[i] = 1'b1;
    end
  endfunction

  // Highest set index of v (0 when v is empty).
  function automatic int unsigned pick_msb(input logic [MAX_N-1:0] v);
    pick_msb = 0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (v[i]) pick_msb = i;
    end
  endfunction

  // Lowest set index of v (0 when v is empty).
  function automatic int unsigned pick_lsb(input logic [MAX_N-1:0] v);
    pick_lsb = 0;
    for (int unsigned i = MAX_N; i > 0; i--) begin
      if (v[i-1]) pick_lsb = i - 1;
    end
  endfunction

endpackage

// File: rtl/pending_priority_encoder_prio_pick.sv
// Combinational fixed-priority picker: vector -> index, one-hot mask, any.
// MSB-first by default; LSB-first when PRIO_LSB_FIRST_EN is defined.
module prio_pick
  import pend_enc_pkg::*;
#(
  parameter  int unsigned N = DEFAULT_N,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic [N-1:0] mask,
  output logic         any
);

  logic [MAX_N-1:0] vec_ext;
  logic [MAX_N-1:0] mask_ext;
  int unsigned      sel;
  logic             unused_bits;

  // Widen to the helper width, pick the winner, narrow the results back.
  always_comb begin
    vec_ext = '0;
    vec_ext[N-1:0] = vec;
`ifdef PRIO_LSB_FIRST_EN
    sel = pick_lsb(vec_ext);
`else
    sel = pick_msb(vec_ext);
`endif
    any      = |vec;
    mask_ext = any ? onehot(sel) : '0;
    idx      = sel[W-1:0];
    mask     = mask_ext[N-1:0];
    unused_bits = ^{mask_ext, sel};
  end

endmodule

// File: rtl/pending_priority_encoder.sv
// Sticky multi-hot request capture feeding a one-entry valid/ready output
// stage that emits one binary index per transfer in fixed priority order.
// Optional macro: PRIO_LSB_FIRST_EN selects LSB-first priority.
module pending_priority_encoder
  import pend_enc_pkg::*;
#(
  parameter  int unsigned N = DEFAULT_N,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_in,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         dup
);

  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] out_idx_q, out_idx_d;
  logic         out_valid_q, out_valid_d;
  logic         dup_q, dup_d;

  logic [N-1:0]     merged;
  logic             load;
  logic [N-1:0]     held_mask;
  logic [W-1:0]     pick_idx;
  logic [N-1:0]     pick_mask;
  logic             pick_any;
  int unsigned      idx_u;
  logic [MAX_N-1:0] held_ext;
  logic             unused_held;

  assign merged = pending_q | req_in;

  prio_pick #(.N(N)) u_pick (
    .vec  (merged),
    .idx  (pick_idx),
    .mask (pick_mask),
    .any  (pick_any)
  );

  // Next-state: handshake, pending merge and duplicate detection.
  always_comb begin
    idx_u = '0;
    idx_u[W-1:0] = out_idx_q;
    held_ext    = onehot(idx_u);
    unused_held = ^held_ext;
    load      = !out_valid_q || out_ready;
    held_mask = (out_valid_q && !out_ready) ? held_ext[N-1:0] : '0;
    dup_d     = |(req_in & (pending_q | held_mask));

    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    // A repeat of the held index merges into that grant, not into pending.
    pending_d   = merged & ~held_mask;
    if (load) begin
      if (pick_any) begin
        out_idx_d   = pick_idx;
        out_valid_d = 1'b1;
        pending_d   = merged & ~pick_mask;
      end else begin
        out_valid_d = 1'b0;
        pending_d   = '0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q   <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      dup_q       <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      dup_q       <= dup_d;
    end
  end

  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign pending   = pending_q;
  assign dup       = dup_q;

endmodule
